branch_pc_unit: RTL and testbench

- Program-counter and branch-redirect stage. It consumes the `zero` (branch-taken) flag from the EX-stage branch comparator and drives the fetch address.
- Sequences reset boot, increments PC, applies stall, and redirects PC for taken branches (EX) and jumps (ID).
- Generates the combinational flush strobes for the IF/ID and ID/EX pipeline registers.
- Keeps a saturating taken-branch counter for debug.

---
 rtl/branch_pc_unit.sv | 116 +++++++++++
 tb/tb_branch_pc_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC sequencing, branch/jump redirect, pipeline flush strobes,
// and a saturating taken-branch counter. Optional macro: BRANCH_DELAY_SLOT_EN.
// Ports:
//   clk, rst          - clock (rising edge) and asynchronous active-high reset
//   stall             - hazard hold request; PC keeps its value
//   br_valid, zero    - EX conditional branch present / condition true
//   br_target         - EX branch target
//   jump_valid        - ID holds j/jal/jr
//   jump_target       - ID jump target
//   pc, pc_plus4      - registered fetch address and pc+4 (mod 2^32)
//   fetch_valid       - IF output is a real instruction
//   flush_ifid/idex   - combinational pipeline-register clear strobes
//   taken_cnt         - saturating count of taken branches
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             zero,
  input  logic [31:0]      br_target,
  input  logic             jump_valid,
  input  logic [31:0]      jump_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIR
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic             r_fetch_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_br_take;
  logic             w_jmp_take;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_pc_next;

  // BOOT ignores every input. In REDIR, EX holds a flushed bubble,
  // except with delay slots, where the slot instruction may branch.
`ifdef BRANCH_DELAY_SLOT_EN
  assign w_br_take = br_valid & zero & (r_state != S_BOOT);
`else
  assign w_br_take = br_valid & zero & (r_state == S_RUN);
`endif

  // A jump alongside a taken branch is on the wrong path.
  assign w_jmp_take = jump_valid & ~w_br_take & (r_state == S_RUN);

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_br_take)
      w_pc_next = br_target;
    else if (w_jmp_take)
      w_pc_next = jump_target;
    else if (stall)
      w_pc_next = r_pc;
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // Delay slot in ID survives a branch; IF holds the slot after a jump.
  assign flush_ifid = w_br_take;
  assign flush_idex = 1'b0;
`else
  assign flush_ifid = w_br_take | w_jmp_take;
  assign flush_idex = w_br_take;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_cnt         <= '0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          r_state       <= S_RUN;
          r_pc          <= RESET_PC;
          r_fetch_valid <= 1'b1;
        end
        S_RUN, S_REDIR: begin
          r_state       <= w_br_take ? S_REDIR : S_RUN;
          r_pc          <= w_pc_next;
          r_fetch_valid <= 1'b1;
        end
        default: begin
          r_state       <= S_BOOT;
          r_pc          <= RESET_PC;
          r_fetch_valid <= 1'b0;
        end
      endcase
      if (w_br_take && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_valid = r_fetch_valid;
  assign taken_cnt   = r_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: table-driven directed vectors plus hand sequences
// for REDIR handling, async reset mid-redirect and counter saturation.
module tb_branch_pc_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic JF = ~DS;
  localparam logic BX = ~DS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] br_target = '0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = '0;

  logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
  logic        fv, fi, fx, fv_b, fi_b, fx_b;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_pc_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_valid(br_valid), .zero(zero), .br_target(br_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fv),
    .flush_ifid(fi), .flush_idex(fx), .taken_cnt(cnt)
  );

  branch_pc_unit #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .stall(stall),
    .br_valid(br_valid), .zero(zero), .br_target(br_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .fetch_valid(fv_b),
    .flush_ifid(fi_b), .flush_idex(fx_b), .taken_cnt(cnt2)
  );

  typedef struct {
    logic        st;
    logic        bv;
    logic        z;
    logic [31:0] bt;
    logic        jv;
    logic [31:0] jt;
    logic [31:0] epc;
    logic        efv;
    logic        efi;
    logic        efx;
    int          ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic bv, input logic z,
                       input logic [31:0] bt, input logic jv,
                       input logic [31:0] jt);
    stall = st; br_valid = bv; zero = z;
    br_target = bt; jump_valid = jv; jump_target = jt;
  endtask

  task automatic chk_fl(input string nm, input logic efi, input logic efx);
    chk({nm, "_fi"}, {31'd0, fi}, {31'd0, efi});
    chk({nm, "_fx"}, {31'd0, fx}, {31'd0, efx});
  endtask

  initial begin
    //        st bv z  bt            jv jt     epc          fv fi  fx  cnt
    vq.push_back('{0, 1, 1, 32'h500,      0, 0,      32'h0,       0, 0,  0,  0});
    vq.push_back('{0, 0, 0, 0,            0, 0,      32'h0,       1, 0,  0,  0});
    vq.push_back('{0, 0, 0, 0,            0, 0,      32'h4,       1, 0,  0,  0});
    vq.push_back('{0, 0, 0, 0,            0, 0,      32'h8,       1, 0,  0,  0});
    vq.push_back('{0, 0, 0, 0,            1, 32'h20, 32'hC,       1, JF, 0,  0});
    vq.push_back('{0, 1, 1, 32'h100,      0, 0,      32'h20,      1, 1,  BX, 0});
    vq.push_back('{0, 0, 0, 0,            1, 32'h800,32'h100,     1, 0,  0,  1});
    vq.push_back('{0, 1, 0, 32'h900,      0, 0,      32'h104,     1, 0,  0,  1});
    vq.push_back('{0, 0, 0, 0,            1, 32'h40, 32'h108,     1, JF, 0,  1});
    vq.push_back('{1, 0, 0, 0,            0, 0,      32'h40,      1, 0,  0,  1});
    vq.push_back('{1, 0, 0, 0,            0, 0,      32'h40,      1, 0,  0,  1});
    vq.push_back('{1, 0, 0, 0,            0, 0,      32'h40,      1, 0,  0,  1});
    vq.push_back('{0, 0, 0, 0,            0, 0,      32'h40,      1, 0,  0,  1});
    vq.push_back('{1, 0, 0, 0,            1, 32'h60, 32'h44,      1, JF, 0,  1});
    vq.push_back('{1, 1, 1, 32'h80,       0, 0,      32'h60,      1, 1,  BX, 1});
    vq.push_back('{1, 0, 0, 0,            0, 0,      32'h80,      1, 0,  0,  2});
    vq.push_back('{0, 1, 1, 32'h200,      1, 32'h300,32'h80,      1, 1,  BX, 2});
    vq.push_back('{0, 0, 0, 0,            0, 0,      32'h200,     1, 0,  0,  3});
    vq.push_back('{0, 1, 1, 32'hFFFFFFFC, 0, 0,      32'h204,     1, 1,  BX, 3});
    vq.push_back('{0, 0, 0, 0,            0, 0,      32'hFFFFFFFC,1, 0,  0,  4});
    vq.push_back('{0, 1, 1, 32'h10,       0, 0,      32'h0,       1, 1,  BX, 4});
    vq.push_back('{0, 0, 0, 0,            0, 0,      32'h10,      1, 0,  0,  5});

    // reset state
    @(negedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'd0, fv}, 32'd0);
    chk_fl("rst", 1'b0, 1'b0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].bv, vq[i].z, vq[i].bt, vq[i].jv, vq[i].jt);
      #1;
      chk($sformatf("v%0d_pc", i), pc, vq[i].epc);
      chk($sformatf("v%0d_pc4", i), pc_plus4, vq[i].epc + 32'd4);
      chk($sformatf("v%0d_fv", i), {31'd0, fv}, {31'd0, vq[i].efv});
      chk_fl($sformatf("v%0d", i), vq[i].efi, vq[i].efx);
      chk($sformatf("v%0d_cnt", i), {16'd0, cnt}, vq[i].ecnt);
      chk($sformatf("v%0d_cnt2", i), {30'd0, cnt2},
          (vq[i].ecnt > 3) ? 32'd3 : vq[i].ecnt);
      @(negedge clk);
    end

    // RUN at pc=0x14: branch in REDIR is ignored (honoured with delay slots)
    drive(0, 1, 1, 32'h100, 0, 0);
    #1;
    chk("a_pc", pc, 32'h14);
    chk_fl("a_br", 1'b1, BX);
    @(negedge clk);
    drive(0, 1, 1, 32'h900, 1, 32'h700);
    #1;
    chk("a_redir_pc", pc, 32'h100);
    chk_fl("a_redir", DS, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("a_next_pc", pc, DS ? 32'h900 : 32'h104);
    chk("a_cnt", {16'd0, cnt}, DS ? 32'd7 : 32'd6);
    chk("a_cnt2", {30'd0, cnt2}, 32'd3);
    @(negedge clk);

    // async reset during REDIR at pc=0x100
    drive(0, 1, 1, 32'h100, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, 32'h300, 1, 32'h400);
    #1;
    chk("b_redir_pc", pc, 32'h100);
    #2;
    rst = 1'b1;
    #1;
    chk("b_rst_pc", pc, 32'h0);
    chk("b_rst_fv", {31'd0, fv}, 32'd0);
    chk_fl("b_rst", 1'b0, 1'b0);
    chk("b_rst_cnt", {16'd0, cnt}, 32'd0);
    chk("b_rst_cnt2", {30'd0, cnt2}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("b_boot_pc", pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("b_run_pc", pc, 32'h4);
    chk("b_run_fv", {31'd0, fv}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
